// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and address-split width helpers for set_assoc_cache
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        WRITE_MEM,
        RESPOND,
        RELEASE
    } state_t;

    function automatic int log2_bits(input int n);
        return (n > 1) ? $clog2(n) : 0;
    endfunction

    function automatic int offset_bits(input int words_per_line);
        return log2_bits(words_per_line);
    endfunction

    function automatic int index_bits(input int sets);
        return log2_bits(sets);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int sets, input int words_per_line);
        return addr_bits - index_bits(sets) - offset_bits(words_per_line);
    endfunction

    // Width of a select/pointer field; never zero so it can always be declared
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last grant
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic          grant_valid_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = last_q;
        cand          = last_q;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_q) + i) % N);
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else if (advance_i && grant_valid_o) begin
            last_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-through data cache shared by the LSU channels
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int CHANNELS       = 4,
    parameter int SETS           = 8,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lsu_read_valid    [CHANNELS],
    input  logic [ADDR_BITS-1:0] lsu_read_address  [CHANNELS],
    output logic                 lsu_read_ready    [CHANNELS],
    output logic [DATA_BITS-1:0] lsu_read_data     [CHANNELS],
    input  logic                 lsu_write_valid   [CHANNELS],
    input  logic [ADDR_BITS-1:0] lsu_write_address [CHANNELS],
    input  logic [DATA_BITS-1:0] lsu_write_data    [CHANNELS],
    output logic                 lsu_write_ready   [CHANNELS],
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    input  logic                 invalidate,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int TAG_BITS = tag_bits(ADDR_BITS, SETS, WORDS_PER_LINE);
    localparam int OFF_W    = sel_width(WORDS_PER_LINE);
    localparam int IDX_W    = sel_width(SETS);
    localparam int WAY_W    = sel_width(WAYS);
    localparam int CH_W     = sel_width(CHANNELS);

    typedef struct packed {
        logic                                      valid;
        logic [TAG_BITS-1:0]                       tag;
        logic [WORDS_PER_LINE-1:0][DATA_BITS-1:0]  data;
    } cache_line_t;

    cache_line_t          lines_q [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q    [SETS];
    state_t               state_q;
    logic [CH_W-1:0]      ch_q;
    logic                 op_write_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [OFF_W-1:0]     fill_k_q;
    logic [WAY_W-1:0]     way_q;
    logic                 inval_pend_q;
    logic [15:0]          hit_cnt_q, miss_cnt_q;
    logic                 rd_ready_q [CHANNELS];
    logic [DATA_BITS-1:0] rd_data_q  [CHANNELS];
    logic                 wr_ready_q [CHANNELS];
    logic                 mem_rd_valid_q, mem_wr_valid_q;
    logic [ADDR_BITS-1:0] mem_rd_addr_q, mem_wr_addr_q;
    logic [DATA_BITS-1:0] mem_wr_data_q;

    logic [CHANNELS-1:0]  req_vec;
    logic                 grant_valid;
    logic [CH_W-1:0]      grant_idx;

    always_comb begin
        req_vec = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            req_vec[c] = lsu_read_valid[c] | lsu_write_valid[c];
        end
    end

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_vec),
        .advance_i     (state_q == IDLE),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    logic [OFF_W-1:0]     req_off;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic [ADDR_BITS-1:0] fill_addr;

    assign req_off   = OFF_W'(int'(addr_q) % WORDS_PER_LINE);
    assign req_idx   = IDX_W'((int'(addr_q) / WORDS_PER_LINE) % SETS);
    assign req_tag   = TAG_BITS'(int'(addr_q) / (WORDS_PER_LINE * SETS));
    assign fill_addr = ADDR_BITS'((int'(addr_q) / WORDS_PER_LINE) * WORDS_PER_LINE + int'(fill_k_q));

    logic                 hit, victim_free;
    logic [WAY_W-1:0]     hit_way, victim_way;
    logic [DATA_BITS-1:0] hit_word;

    // Victim is the lowest invalid way; the set's rr pointer only breaks ties when the set is full
    always_comb begin
        hit         = 1'b0;
        hit_way     = '0;
        victim_free = 1'b0;
        victim_way  = rr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && lines_q[req_idx][w].valid && lines_q[req_idx][w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!victim_free && !lines_q[req_idx][w].valid) begin
                victim_free = 1'b1;
                victim_way  = WAY_W'(w);
            end
        end
    end

    assign hit_word = lines_q[req_idx][hit_way].data[req_off];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    lines_q[s][w] <= '0;
                end
            end
            for (int c = 0; c < CHANNELS; c++) begin
                rd_ready_q[c] <= 1'b0;
                rd_data_q[c]  <= '0;
                wr_ready_q[c] <= 1'b0;
            end
            state_q        <= IDLE;
            ch_q           <= '0;
            op_write_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            fill_k_q       <= '0;
            way_q          <= '0;
            inval_pend_q   <= 1'b0;
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
        end else begin
            if (invalidate && state_q != IDLE) begin
                inval_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (invalidate || inval_pend_q) begin
                        inval_pend_q <= 1'b0;
                        for (int s = 0; s < SETS; s++) begin
                            rr_q[s] <= '0;
                            for (int w = 0; w < WAYS; w++) begin
                                lines_q[s][w].valid <= 1'b0;
                            end
                        end
                    end
                    if (grant_valid) begin
                        ch_q       <= grant_idx;
                        op_write_q <= !lsu_read_valid[grant_idx];
                        addr_q     <= lsu_read_valid[grant_idx] ? lsu_read_address[grant_idx]
                                                                : lsu_write_address[grant_idx];
                        wdata_q    <= lsu_write_data[grant_idx];
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!op_write_q) begin
                        if (hit) begin
                            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
                            rd_ready_q[ch_q] <= 1'b1;
                            rd_data_q[ch_q]  <= hit_word;
                            state_q          <= RESPOND;
                        end else begin
                            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
                            if (!victim_free) begin
                                rr_q[req_idx] <= WAY_W'((int'(rr_q[req_idx]) + 1) % WAYS);
                            end
                            lines_q[req_idx][victim_way].valid <= 1'b0;
                            way_q    <= victim_way;
                            fill_k_q <= '0;
                            state_q  <= FILL_REQ;
                        end
                    end else begin
                        if (hit) begin
                            lines_q[req_idx][hit_way].data[req_off] <= wdata_q;
                        end
                        mem_wr_valid_q <= 1'b1;
                        mem_wr_addr_q  <= addr_q;
                        mem_wr_data_q  <= wdata_q;
                        state_q        <= WRITE_MEM;
                    end
                end
                FILL_REQ: begin
                    mem_rd_valid_q <= 1'b1;
                    mem_rd_addr_q  <= fill_addr;
                    state_q        <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem_read_ready) begin
                        mem_rd_valid_q <= 1'b0;
                        lines_q[req_idx][way_q].data[fill_k_q] <= mem_read_data;
                        if (fill_k_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                            lines_q[req_idx][way_q].tag   <= req_tag;
                            lines_q[req_idx][way_q].valid <= 1'b1;
                            rd_ready_q[ch_q] <= 1'b1;
                            rd_data_q[ch_q]  <= (fill_k_q == req_off) ? mem_read_data
                                                : lines_q[req_idx][way_q].data[req_off];
                            state_q          <= RESPOND;
                        end else begin
                            fill_k_q <= fill_k_q + OFF_W'(1);
                            state_q  <= FILL_REQ;
                        end
                    end
                end
                WRITE_MEM: begin
                    if (mem_write_ready) begin
                        mem_wr_valid_q   <= 1'b0;
                        wr_ready_q[ch_q] <= 1'b1;
                        state_q          <= RESPOND;
                    end
                end
                RESPOND: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        rd_ready_q[c] <= 1'b0;
                        rd_data_q[c]  <= '0;
                        wr_ready_q[c] <= 1'b0;
                    end
                    state_q <= RELEASE;
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_read_ready    = rd_ready_q;
    assign lsu_read_data     = rd_data_q;
    assign lsu_write_ready   = wr_ready_q;
    assign mem_read_valid    = mem_rd_valid_q;
    assign mem_read_address  = mem_rd_addr_q;
    assign mem_write_valid   = mem_wr_valid_q;
    assign mem_write_address = mem_wr_addr_q;
    assign mem_write_data    = mem_wr_data_q;
    assign hit_count         = hit_cnt_q;
    assign miss_count        = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - directed and random checks of set_assoc_cache against a set/way reference model
module tb_set_assoc_cache;

    localparam int AB = 8, DB = 8, CH = 4, SETS = 8, WAYS = 2, WPL = 2;
    localparam int BUDGET = 200;

    logic          clk;
    logic          reset;
    logic          lsu_read_valid    [CH];
    logic [AB-1:0] lsu_read_address  [CH];
    logic          lsu_read_ready    [CH];
    logic [DB-1:0] lsu_read_data     [CH];
    logic          lsu_write_valid   [CH];
    logic [AB-1:0] lsu_write_address [CH];
    logic [DB-1:0] lsu_write_data    [CH];
    logic          lsu_write_ready   [CH];
    logic          mem_read_valid, mem_read_ready, mem_write_valid, mem_write_ready;
    logic [AB-1:0] mem_read_address, mem_write_address;
    logic [DB-1:0] mem_read_data, mem_write_data;
    logic          invalidate;
    logic [15:0]   hit_count, miss_count;

    set_assoc_cache #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH),
        .SETS(SETS), .WAYS(WAYS), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk(clk), .reset(reset),
        .lsu_read_valid(lsu_read_valid), .lsu_read_address(lsu_read_address),
        .lsu_read_ready(lsu_read_ready), .lsu_read_data(lsu_read_data),
        .lsu_write_valid(lsu_write_valid), .lsu_write_address(lsu_write_address),
        .lsu_write_data(lsu_write_data), .lsu_write_ready(lsu_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .invalidate(invalidate), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing store seen by the DUT, and the value the bench believes each address holds
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    int         rd_count = 0;
    int         wr_count = 0;
    logic [7:0] rd_log [$];
    logic [7:0] wr_last_addr, wr_last_data;

    initial begin
        int lat;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_read_valid === 1'b1 && reset === 1'b0) begin
                lat = $urandom_range(0, 2);
                repeat (lat) @(negedge clk);
                if (mem_read_valid === 1'b1) begin
                    mem_read_data  = mem[mem_read_address];
                    mem_read_ready = 1'b1;
                    rd_count++;
                    rd_log.push_back(mem_read_address);
                    @(negedge clk);
                    mem_read_ready = 1'b0;
                    mem_read_data  = '0;
                end
            end
        end
    end

    initial begin
        int lat;
        mem_write_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_write_valid === 1'b1 && reset === 1'b0) begin
                lat = $urandom_range(0, 2);
                repeat (lat) @(negedge clk);
                if (mem_write_valid === 1'b1) begin
                    mem[mem_write_address] = mem_write_data;
                    wr_last_addr    = mem_write_address;
                    wr_last_data    = mem_write_data;
                    wr_count++;
                    mem_write_ready = 1'b1;
                    @(negedge clk);
                    mem_write_ready = 1'b0;
                end
            end
        end
    end

    // Reference cache: which tag each way of each set holds, plus the replacement pointer
    bit m_valid [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_rr    [SETS];
    int m_hits  = 0;
    int m_miss  = 0;

    function automatic void model_invalidate();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 0;
        end
    endfunction

    function automatic bit model_read(input int addr);
        int s, t, v;
        s = (addr / WPL) % SETS;
        t = addr / (WPL * SETS);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                m_hits++;
                return 1'b1;
            end
        end
        m_miss++;
        v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[s][v] = 1;
        m_tag[s][v]   = t;
        return 1'b0;
    endfunction

    function automatic int others_busy(input int ch);
        int n = 0;
        for (int c = 0; c < CH; c++) begin
            if (c != ch && (lsu_read_ready[c] !== 1'b0 || lsu_read_data[c] !== '0 || lsu_write_ready[c] !== 1'b0)) n++;
        end
        return n;
    endfunction

    task automatic do_read(input int ch, input int addr, input int inval_at);
        int  cycles, rd0;
        bit  exp_hit;
        logic [7:0] exp_data;
        exp_hit  = model_read(addr);
        exp_data = ref_mem[addr];
        rd0      = rd_count;
        lsu_read_valid[ch]   = 1'b1;
        lsu_read_address[ch] = AB'(addr);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            invalidate = (cycles == inval_at);
        end while (lsu_read_ready[ch] !== 1'b1 && cycles < BUDGET);
        invalidate = 1'b0;
        lsu_read_valid[ch] = 1'b0;
        check("rd_in_budget", cycles < BUDGET, 1);
        check("rd_data", lsu_read_data[ch], exp_data);
        check("rd_others_idle", others_busy(ch), 0);
        check("rd_mem_reads", rd_count - rd0, exp_hit ? 0 : WPL);
        if (exp_hit) check("rd_hit_latency", cycles, 2);
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_miss);
        if (inval_at > 0) model_invalidate();
        @(negedge clk);
        check("rd_pulse_width", lsu_read_ready[ch], 0);
        @(negedge clk);
    endtask

    task automatic do_write(input int ch, input int addr, input logic [7:0] data);
        int cycles, wr0, rd0;
        ref_mem[addr] = data;
        wr0 = wr_count;
        rd0 = rd_count;
        lsu_write_valid[ch]   = 1'b1;
        lsu_write_address[ch] = AB'(addr);
        lsu_write_data[ch]    = data;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (lsu_write_ready[ch] !== 1'b1 && cycles < BUDGET);
        lsu_write_valid[ch] = 1'b0;
        check("wr_in_budget", cycles < BUDGET, 1);
        check("wr_mem_writes", wr_count - wr0, 1);
        check("wr_mem_addr", wr_last_addr, addr);
        check("wr_mem_data", wr_last_data, data);
        check("wr_no_fill", rd_count - rd0, 0);
        check("wr_others_idle", others_busy(ch), 0);
        check("wr_counters", {hit_count, miss_count}, {16'(m_hits), 16'(m_miss)});
        @(negedge clk);
        check("wr_pulse_width", lsu_write_ready[ch], 0);
        @(negedge clk);
    endtask

    // Raise several channels together and record the order and cycle of their ready pulses
    task automatic multi_read(input int n, input int chs [4], input int addrs [4],
                              output int order [4], output int stamp [4]);
        int got, cyc, rd0;
        rd0 = rd_count;
        for (int i = 0; i < n; i++) begin
            lsu_read_valid[chs[i]]   = 1'b1;
            lsu_read_address[chs[i]] = AB'(addrs[i]);
        end
        got = 0;
        cyc = 0;
        while (got < n && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < CH; c++) begin
                if (lsu_read_valid[c] && lsu_read_ready[c] === 1'b1) begin
                    order[got] = c;
                    stamp[got] = cyc;
                    got++;
                    check("multi_data", lsu_read_data[c], ref_mem[lsu_read_address[c]]);
                    void'(model_read(int'(lsu_read_address[c])));
                    lsu_read_valid[c] = 1'b0;
                end
            end
        end
        check("multi_in_budget", got, n);
        check("multi_no_fill", rd_count - rd0, 0);
        check("multi_hits", hit_count, m_hits);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int order [4];
        int stamp [4];
        int chs [4];
        int addrs [4];
        int sel, ch, addr;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h12] = 8'hA0; ref_mem[8'h12] = 8'hA0;
        mem[8'h13] = 8'hA1; ref_mem[8'h13] = 8'hA1;
        model_invalidate();
        reset = 1'b1;
        invalidate = 1'b0;
        for (int c = 0; c < CH; c++) begin
            lsu_read_valid[c] = 1'b0;  lsu_read_address[c] = '0;
            lsu_write_valid[c] = 1'b0; lsu_write_address[c] = '0; lsu_write_data[c] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_mem_rd_valid", mem_read_valid, 0);
        check("reset_mem_wr_valid", mem_write_valid, 0);
        check("reset_lsu_outputs", others_busy(-1), 0);
        check("reset_counters", {hit_count, miss_count}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss fills both words of the line, then a hit on the second word
        do_read(0, 'h12, 0);
        check("cold_fill_addr0", rd_log[rd_log.size() - 2], 8'h12);
        check("cold_fill_addr1", rd_log[rd_log.size() - 1], 8'h13);
        do_read(0, 'h13, 0);
        do_read(1, 'h14, 0);
        do_read(3, 'h12, 0);

        chs = '{0, 1, 2, 3};
        addrs = '{'h12, 'h13, 'h14, 'h15};
        multi_read(4, chs, addrs, order, stamp);
        for (int i = 0; i < 4; i++) check("rr_order", order[i], i);
        for (int i = 1; i < 4; i++) check("rr_spacing", stamp[i] - stamp[i-1], 4);

        do_read(2, 'h14, 0);
        chs = '{0, 3, 0, 0};
        addrs = '{'h13, 'h15, 0, 0};
        multi_read(2, chs, addrs, order, stamp);
        check("rr_after_ch2_first", order[0], 3);
        check("rr_after_ch2_second", order[1], 0);

        // Three tags in set 4: the third evicts the first
        do_read(0, 'h08, 0);
        do_read(0, 'h28, 0);
        do_read(0, 'h48, 0);
        do_read(0, 'h08, 0);
        do_read(0, 'h48, 0);
        do_read(0, 'h28, 0);

        do_read(1, 'h20, 0);
        do_write(1, 'h20, 8'h55);
        do_read(1, 'h20, 0);
        do_write(2, 'h40, 8'h3C);
        do_read(2, 'h40, 0);

        // Invalidate while the fill is in flight
        do_read(1, 'h60, 3);
        do_read(1, 'h60, 0);
        do_read(1, 'h20, 0);

        // Reset in the middle of a fill
        lsu_read_valid[2]   = 1'b1;
        lsu_read_address[2] = 8'h70;
        sel = 0;
        do begin
            @(negedge clk);
            sel++;
        end while (mem_read_valid !== 1'b1 && sel < BUDGET);
        check("fill_started", sel < BUDGET, 1);
        #1 reset = 1'b1;
        #1;
        check("reset_drops_mem_rd", mem_read_valid, 0);
        check("reset_lsu_idle", others_busy(-1), 0);
        check("reset_clears_counts", {hit_count, miss_count}, 0);
        lsu_read_valid[2] = 1'b0;
        model_invalidate();
        m_hits = 0;
        m_miss = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        do_read(2, 'h70, 0);
        do_read(0, 'h12, 0);

        for (int i = 0; i < 40; i++) begin
            ch   = $urandom_range(0, CH - 1);
            addr = $urandom_range(0, 3) * (WPL * SETS) + $urandom_range(2, 3) * WPL + $urandom_range(0, WPL - 1);
            sel  = $urandom_range(0, 9);
            if (sel < 6) begin
                do_read(ch, addr, 0);
            end else if (sel < 9) begin
                do_write(ch, addr, 8'($urandom));
            end else begin
                invalidate = 1'b1;
                @(negedge clk);
                invalidate = 1'b0;
                model_invalidate();
                do_read(ch, addr, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench still running at %0t, required to have finished", $time);
        $fatal(1);
    end

endmodule
